// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared definitions for the bit-serial adder
//
// Package adder_pkg: FSM state encoding and counter-width helper.

package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width: max(1, clog2(n)). It only has to hold 0..n-1.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/done handshake and operand/result bundle
//
// Signals: start, A, B (controller -> adder); busy, done, S, cout (adder -> controller);
// ovf (adder -> controller) exists only when SERIAL_ADD_OVF_EN is defined.
// Modports: master = controller side, slave = adder side.

interface serial_adder_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         busy;
    logic         done;
    logic [N-1:0] S;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;

    modport master (output start, A, B, input busy, done, S, cout, ovf);
    modport slave  (input start, A, B, output busy, done, S, cout, ovf);
`else
    modport master (output start, A, B, input busy, done, S, cout);
    modport slave  (input start, A, B, output busy, done, S, cout);
`endif
endinterface

// File: rtl/serial_adder_fulladder.sv
// rtl/serial_adder_fulladder.sv - one-bit full adder cell
//
// Ports: a, b, cin (in) -> s (sum), cout (carry out).

module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial N-bit adder, LSB first, one bit per clock
//
// Parameter N (>= 1): operand/result width.
// Ports: clk, rst (async active-high); bus (serial_adder_if.slave):
//   start/A/B sampled in IDLE, busy = not IDLE, done = one-cycle result pulse,
//   S/cout registered result held until the next completion,
//   ovf signed overflow flag (only with SERIAL_ADD_OVF_EN defined).

module serial_adder
    import adder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_if.slave       bus
);
    localparam int CW = cnt_w(N);

    state_t        state, state_next;
    logic [N-1:0]  ra, rb, acc;
    logic [N-1:0]  acc_next;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          fa_s, fa_c;
    logic          last;

    fulladder u_fa (
        .a    (ra[0]),
        .b    (rb[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign last = (cnt == CW'(N - 1));

    // New sum bit enters at the MSB; written as shift-then-insert so N=1 works.
    always_comb begin
        acc_next        = acc >> 1;
        acc_next[N-1]   = fa_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:                   state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra       <= '0;
            rb       <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            bus.S    <= '0;
            bus.cout <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            bus.ovf  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ra    <= bus.A;
                        rb    <= bus.B;
                        carry <= 1'b0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    ra    <= ra >> 1;
                    rb    <= rb >> 1;
                    carry <= fa_c;
                    // Hold at N-1 on the final edge so the counter never wraps.
                    if (!last) cnt <= cnt + CW'(1);
                    if (last) begin
                        bus.S    <= acc_next;
                        bus.cout <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
                        // Sign bits equal but sum sign differs: two's-complement overflow.
                        bus.ovf  <= (ra[0] == rb[0]) && (fa_s != ra[0]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder

module tb_serial_adder;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_adder_if #(.N(N)) bus ();

    serial_adder #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    function automatic logic [N:0] ref_sum(input logic [N-1:0] a, input logic [N-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic ref_ovf(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] s;
        s = a + b;
        return (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for done; lat = edges after acceptance, bc = busy cycles seen.
    task automatic wait_done(input string name, output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (1) begin
            if (bus.busy) bc++;
            if (bus.done) break;
            if (lat > 4 * N + 8) begin
                failures++; checks++;
                $display("FAIL %s timeout: done not seen within %0d cycles", name, lat);
                break;
            end
            tick();
            lat++;
        end
    endtask

    task automatic check_result(input string name, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] e;
        e = ref_sum(a, b);
        checks++;
        if ({bus.cout, bus.S} !== e) begin
            failures++;
            $display("FAIL %s sum: got cout=%0b S=%h want cout=%0b S=%h", name, bus.cout, bus.S, e[N], e[N-1:0]);
        end
`ifdef SERIAL_ADD_OVF_EN
        checks++;
        if (bus.ovf !== ref_ovf(a, b)) begin
            failures++;
            $display("FAIL %s ovf: got %0b want %0b", name, bus.ovf, ref_ovf(a, b));
        end
`endif
    endtask

    // Full single transaction from IDLE, with latency/busy/pulse checks.
    task automatic run_add(input string name, input logic [N-1:0] a, input logic [N-1:0] b);
        int lat, bc;
        bus.A = a; bus.B = b; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.A = ~a; bus.B = ~b;   // late operand changes must not matter
        wait_done(name, lat, bc);
        checks++;
        if (lat !== N) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, N);
        end
        checks++;
        if (bc !== N + 1) begin
            failures++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, bc, N + 1);
        end
        check_result(name, a, b);
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done: got done=%0b busy=%0b want 0 0", name, bus.done, bus.busy);
        end
        check_result({name, "_hold"}, a, b);
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.A = '0; bus.B = '0;
        #1;
        repeat (2) tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.S !== '0 || bus.cout !== 1'b0) begin
            failures++;
            $display("FAIL reset: got busy=%0b done=%0b S=%h cout=%0b want all 0", bus.busy, bus.done, bus.S, bus.cout);
        end
`ifdef SERIAL_ADD_OVF_EN
        checks++;
        if (bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf: got %0b want 0", bus.ovf);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        run_add("dir_5a_3c", 8'h5A, 8'h3C);
        run_add("dir_ff_01", 8'hFF, 8'h01);
    endtask

    task automatic test_ignore_start();
        int lat, bc, ndone;
        bus.A = 8'h21; bus.B = 8'h43; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        bus.A = 8'h11; bus.B = 8'hEE; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done("ignore", lat, bc);
        check_result("ignore", 8'h21, 8'h43);
        ndone = 0;
        for (int i = 0; i < 2 * N + 4; i++) begin
            if (bus.done) ndone++;
            tick();
        end
        checks++;
        if (ndone !== 1) begin
            failures++;
            $display("FAIL ignore_done_count: got %0d want 1", ndone);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, bc;
        bus.A = 8'h01; bus.B = 8'h02; bus.start = 1'b1;
        tick();
        bus.A = 8'h7F; bus.B = 8'h01;   // next operands, start stays high
        wait_done("b2b_first", lat1, bc);
        check_result("b2b_first", 8'h01, 8'h02);
        tick();                          // DONE -> IDLE
        tick();                          // held start re-accepted
        bus.start = 1'b0;
        wait_done("b2b_second", lat2, bc);
        checks++;
        if (lat1 + 2 + lat2 !== N + 2 + N) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d want %0d", lat2 + 2, N + 2);
        end
        check_result("b2b_second", 8'h7F, 8'h01);
        tick();
    endtask

    task automatic test_reset_mid_run();
        bus.A = 8'h33; bus.B = 8'h44; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.S !== '0 || bus.cout !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got busy=%0b done=%0b S=%h cout=%0b want all 0", bus.busy, bus.done, bus.S, bus.cout);
        end
        tick();
        rst = 1'b0;
        tick();
        run_add("after_reset", 8'hC8, 8'h64);
    endtask

    task automatic test_random();
        logic [N-1:0] a, b;
        for (int i = 0; i < 16; i++) begin
            a = N'($urandom);
            b = N'($urandom);
            run_add($sformatf("rand%0d", i), a, b);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
